// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral and its SPI register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam int PRESCALE_DEFAULT = 3000;
  localparam int PRESCALE_W       = 16;

  // Register map shared with the SPI register block.
  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_PWM_DUTY    = 8'h04;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  localparam pwm_cnt_t PWM_CNT_MAX = '1;

  // Full-scale duty must be solidly high, so it bypasses the compare.
  function automatic logic pwm_level_f(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_CNT_MAX) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; one counter step every PRESCALE clk cycles.
// Latency: tick and wrap are combinational from the counter state.
// Backpressure: none, free-running once out of reset.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     tick,
  output pwm_cnt_t pwm_counter,
  output logic     wrap
);

  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] ps_cnt;

  // With PRESCALE = 1 the count sits at 0 and tick stays high every cycle.
  assign tick = (ps_cnt == PS_LAST);
  assign wrap = tick && (pwm_counter == PWM_CNT_MAX);

  // Prescaler counts 0..PRESCALE-1 and returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PRESCALE_W'(1);
    end
  end

  // PWM counter advances on tick and rolls 255 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_counter <= '0;
    end else if (tick) begin
      pwm_counter <= pwm_counter + pwm_cnt_t'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-pin enable / static-high / shared-duty PWM.
// Latency: one clk from enables or counter/duty state to out; period_start aligned with counter-0 on out.
// Backpressure: none; register inputs are sampled every clk.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic        tick;
  logic        wrap;
  logic        wrap_q;
  logic        duty_load;
  logic        pwm_level;
  pwm_cnt_t    pwm_counter;
  pwm_cnt_t    duty_q;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_d;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .pwm_counter (pwm_counter),
    .wrap        (wrap)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Sample duty only on the last step of a period so the new value starts at counter 0.
  assign duty_load = tick && (pwm_counter == PWM_CNT_MAX);

  assign pwm_level = pwm_level_f(pwm_counter, duty_q);

  // Disabled pins low, enabled non-PWM pins high, PWM pins follow the shared level.
  assign out_d = en_out & (~en_pwm | {16{pwm_level}});

  // Duty shadow: mid-period writes are ignored until the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (duty_load) begin
      duty_q <= pwm_duty_cycle;
    end
  end

  // Registered pins, so every PWM-mode output switches on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_d;
    end
  end

  // Two-stage delay of wrap: counter reaches 0, then out shows it alongside period_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wrap_q       <= wrap;
      period_start <= wrap_q;
    end
  end

endmodule
